// File: rtl/write_back_stage.sv
// Writeback stage: registers the EX_WB bus, commits results to a 32x32
// register file with bypass on the decode read ports, counts retired
// instructions and queues a commit trace for a valid/ready consumer.
module write_back_stage #(
   parameter int TRACE_DEPTH = 4,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [70:0]      EX_WB,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic [31:0]      rs1_data,
   output logic [31:0]      rs2_data,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [68:0]      trace_data,
   output logic [CNT_W-1:0] retire_count,
   output logic             trace_overflow
);

   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam int OCC_W = $clog2(TRACE_DEPTH + 1);

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [4:0]  rd;
      logic [31:0] result;
      logic [31:0] pc;
   } wb_t;

   wb_t              wb_q;
   logic [31:0]      regs [32];
   logic [68:0]      fifo_mem [TRACE_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occupancy;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic             do_push;

   assign fifo_full   = (occupancy == OCC_W'(TRACE_DEPTH));
   assign push        = wb_q.valid;
   assign pop         = trace_valid && trace_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push     = push && (!fifo_full || pop);
   assign trace_valid = (occupancy != '0);
   assign trace_data  = fifo_mem[rd_ptr];

   // WB pipeline register; reset discards any pending commit.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_q <= '0;
      end else begin
         wb_q <= wb_t'(EX_WB);
      end
   end

   // Register file commit; r0 is never written so it stays zero.
   // NOTE: the register file is architecturally cleared by reset, so every entry is reset here;
   // the trace FIFO storage below is not, because occupancy already masks stale entries.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_q.valid && wb_q.reg_write && (wb_q.rd != 5'd0)) begin
         regs[wb_q.rd] <= wb_q.result;
      end
   end

   // Retire counter, wraps modulo 2^CNT_W.
   always_ff @(posedge clock) begin
      if (reset) begin
         retire_count <= '0;
      end else if (wb_q.valid) begin
         retire_count <= retire_count + CNT_W'(1);
      end
   end

   // Trace FIFO storage.
   always_ff @(posedge clock) begin
      if (do_push) begin
         fifo_mem[wr_ptr] <= {wb_q.pc, wb_q.rd, wb_q.result};
      end
   end

   // Trace FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         occupancy      <= '0;
         trace_overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, pop})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
         if (push && !do_push) begin
            trace_overflow <= 1'b1;
         end
      end
   end

   // Read port 1: r0 is zero, then bypass from the pending write, then the register file.
   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      rs1_data = '0;
      if (rs1_addr != 5'd0) begin
         if (wb_q.valid && wb_q.reg_write && (wb_q.rd == rs1_addr)) begin
            rs1_data = wb_q.result;
         end else begin
            rs1_data = regs[rs1_addr];
         end
      end
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      rs2_data = '0;
      if (rs2_addr != 5'd0) begin
         if (wb_q.valid && wb_q.reg_write && (wb_q.rd == rs2_addr)) begin
            rs2_data = wb_q.result;
         end else begin
            rs2_data = regs[rs2_addr];
         end
      end
   end

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage. A 32-bit-counter instance and a
// 4-bit-counter instance share all inputs; a queue-based model predicts outputs.
module tb_write_back_stage;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [70:0] EX_WB = '0;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic        trace_ready = 1'b0;

   logic [31:0] rs1_data, rs2_data;
   logic        trace_valid;
   logic [68:0] trace_data;
   logic [31:0] retire_count;
   logic        trace_overflow;

   logic [31:0] w4_rs1_data, w4_rs2_data;
   logic        w4_trace_valid;
   logic [68:0] w4_trace_data;
   logic [3:0]  w4_retire_count;
   logic        w4_trace_overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [70:0] m_pend;
   logic [68:0] mq [$];
   int unsigned m_cnt;
   logic        m_ovf;

   write_back_stage #(.TRACE_DEPTH(DEPTH), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .EX_WB(EX_WB),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
      .retire_count(retire_count), .trace_overflow(trace_overflow)
   );

   write_back_stage #(.TRACE_DEPTH(DEPTH), .CNT_W(4)) dut_w4 (
      .clock(clock), .reset(reset), .EX_WB(EX_WB),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(w4_rs1_data), .rs2_data(w4_rs2_data),
      .trace_valid(w4_trace_valid), .trace_ready(trace_ready), .trace_data(w4_trace_data),
      .retire_count(w4_retire_count), .trace_overflow(w4_trace_overflow)
   );

   always #5 clock = ~clock;

   function automatic logic [70:0] mk_op(input logic rw, input logic [4:0] rd,
                                         input logic [31:0] res, input logic [31:0] pc);
      return {1'b1, rw, rd, res, pc};
   endfunction

   // Architectural view: what a decode read must return right now.
   function automatic logic [31:0] exp_read(input logic [4:0] addr);
      logic [4:0] prd;
      prd = m_pend[68:64];
      if (addr == 5'd0) return 32'h0;
      if (m_pend[70] && m_pend[69] && prd == addr) return m_pend[63:32];
      return m_regs[addr];
   endfunction

   // Model of one clock edge given the inputs held across it.
   task automatic model_edge(input logic [70:0] ex, input logic rdy, input logic rst);
      logic        do_pop;
      logic [4:0]  prd;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_pend = '0;
         mq.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
         return;
      end
      do_pop = (mq.size() > 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (m_pend[70]) begin
         prd = m_pend[68:64];
         if (m_pend[69] && prd != 5'd0) m_regs[prd] = m_pend[63:32];
         m_cnt = m_cnt + 1;
         if (mq.size() < DEPTH) mq.push_back({m_pend[31:0], prd, m_pend[63:32]});
         else m_ovf = 1'b1;
      end
      m_pend = ex;
   endtask

   // Drive inputs, take one edge, advance the model; returns 1 ns after the edge.
   task automatic tick(input logic [70:0] ex, input logic rdy);
      logic rst_now;
      EX_WB = ex;
      trace_ready = rdy;
      rst_now = reset;
      @(posedge clock);
      #1;
      model_edge(ex, rdy, rst_now);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick('0, 1'b0);
      tick('0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rs1_addr = 5'd9; rs2_addr = 5'd31; #1;
      n_tests++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs1: got %h want 0", rs1_data); end
      n_tests++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs2: got %h want 0", rs2_data); end
      n_tests++; if (retire_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", retire_count); end
      n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", trace_valid); end
      n_tests++; if (trace_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", trace_overflow); end
   endtask

   task automatic test_bypass();
      do_reset();
      tick(mk_op(1'b1, 5'd3, 32'hDEAD_BEEF, 32'h100), 1'b1);
      rs1_addr = 5'd3; #1;
      n_tests++; if (rs1_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rs1: got %h want deadbeef", rs1_data); end
      n_tests++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL bypass_count_early: got %0d want 0", retire_count); end
      tick('0, 1'b1);
      n_tests++; if (rs1_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL regfile_rs1: got %h want deadbeef", rs1_data); end
      n_tests++; if (retire_count !== 32'd1) begin n_fail++; $display("FAIL commit_count: got %0d want 1", retire_count); end
      n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL commit_tvalid: got %b want 1", trace_valid); end
      n_tests++; if (trace_data !== {32'h100, 5'd3, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL commit_tdata: got %h want %h", trace_data, {32'h100, 5'd3, 32'hDEAD_BEEF}); end
   endtask

   task automatic test_r0();
      tick('0, 1'b1);  // drain the entry left by the previous test
      tick(mk_op(1'b1, 5'd0, 32'h1234, 32'h200), 1'b0);
      rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
      n_tests++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL r0_bypass_rs1: got %h want 0", rs1_data); end
      n_tests++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL r0_bypass_rs2: got %h want 0", rs2_data); end
      tick('0, 1'b0);
      n_tests++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL r0_rs1: got %h want 0", rs1_data); end
      n_tests++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL r0_rs2: got %h want 0", rs2_data); end
      n_tests++; if (retire_count !== 32'd2) begin n_fail++; $display("FAIL r0_count: got %0d want 2", retire_count); end
      n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL r0_tvalid: got %b want 1", trace_valid); end
      n_tests++; if (trace_data !== {32'h200, 5'd0, 32'h1234}) begin n_fail++; $display("FAIL r0_tdata: got %h want %h", trace_data, {32'h200, 5'd0, 32'h1234}); end
   endtask

   task automatic test_overflow();
      logic [31:0] last_res;
      do_reset();
      last_res = '0;
      for (int i = 0; i <= DEPTH; i++) begin
         last_res = $urandom;
         tick(mk_op(1'b1, 5'(i + 1), last_res, 32'(4 * i)), 1'b0);
      end
      n_tests++; if (trace_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", trace_overflow); end
      tick('0, 1'b0);
      n_tests++; if (trace_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", trace_overflow); end
      n_tests++; if (retire_count !== 32'(DEPTH + 1)) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", retire_count, DEPTH + 1); end
      rs1_addr = 5'(DEPTH + 1); #1;
      n_tests++; if (rs1_data !== last_res) begin n_fail++; $display("FAIL ovf_regwrite: got %h want %h", rs1_data, last_res); end
      for (int j = 0; j < DEPTH; j++) begin
         n_tests++; if (trace_valid !== 1'b1 || trace_data[68:37] !== 32'(4 * j)) begin
            n_fail++; $display("FAIL ovf_pop_pc%0d: got v=%b pc=%h want v=1 pc=%h", j, trace_valid, trace_data[68:37], 32'(4 * j));
         end
         tick('0, 1'b1);
      end
      n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", trace_valid); end
      n_tests++; if (trace_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", trace_overflow); end
   endtask

   task automatic test_full_push_pop();
      int          seen;
      logic [31:0] last_pc;
      do_reset();
      for (int i = 0; i <= DEPTH; i++) tick(mk_op(1'b1, 5'd10, 32'(i), 32'h1000 + 32'(4 * i)), 1'b0);
      // FIFO now full with ops 0..3, op 4 pending: pop and push share the next edge.
      tick('0, 1'b1);
      n_tests++; if (trace_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b want 0", trace_overflow); end
      n_tests++; if (trace_data[68:37] !== 32'h1004) begin n_fail++; $display("FAIL fpp_head: got %h want 00001004", trace_data[68:37]); end
      seen = 0; last_pc = '0;
      for (int k = 0; k < 2 * DEPTH && trace_valid === 1'b1; k++) begin
         seen++;
         last_pc = trace_data[68:37];
         tick('0, 1'b1);
      end
      n_tests++; if (seen != DEPTH) begin n_fail++; $display("FAIL fpp_occupancy: got %0d want %0d", seen, DEPTH); end
      n_tests++; if (last_pc !== 32'h1010) begin n_fail++; $display("FAIL fpp_last_pc: got %h want 00001010", last_pc); end
   endtask

   task automatic test_reset_pending();
      do_reset();
      for (int i = 0; i <= DEPTH; i++) tick(mk_op(1'b1, 5'd2, 32'hAAAA_0000, 32'(i)), 1'b0);
      tick(mk_op(1'b1, 5'd7, 32'h5555_1234, 32'h300), 1'b0);
      reset = 1'b1;
      tick('0, 1'b0);
      reset = 1'b0;
      rs1_addr = 5'd7; rs2_addr = 5'd2; #1;
      n_tests++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL rp_rs1: got %h want 0", rs1_data); end
      n_tests++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL rp_rs2: got %h want 0", rs2_data); end
      tick('0, 1'b0);
      n_tests++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL rp_discard: got %h want 0", rs1_data); end
      n_tests++; if (retire_count !== 32'h0) begin n_fail++; $display("FAIL rp_count: got %0d want 0", retire_count); end
      n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rp_tvalid: got %b want 0", trace_valid); end
      n_tests++; if (trace_overflow !== 1'b0) begin n_fail++; $display("FAIL rp_ovf: got %b want 0", trace_overflow); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 15; i++) tick(mk_op(1'b0, 5'd0, 32'(i), 32'(i)), 1'b1);
      tick('0, 1'b1);
      n_tests++; if (w4_retire_count !== 4'd15) begin n_fail++; $display("FAIL wrap_pre: got %0d want 15", w4_retire_count); end
      tick(mk_op(1'b0, 5'd0, 32'h0, 32'h0), 1'b1);
      tick('0, 1'b1);
      n_tests++; if (w4_retire_count !== 4'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", w4_retire_count); end
      n_tests++; if (retire_count !== 32'd16) begin n_fail++; $display("FAIL wrap_wide: got %0d want 16", retire_count); end
   endtask

   task automatic test_random();
      logic [70:0] ex;
      logic [4:0]  prd;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         ex = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom), 5'($urandom),
               32'($urandom), 32'($urandom)};
         reset = ($urandom_range(0, 99) == 0);
         tick(ex, ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
         reset = 1'b0;
         prd = m_pend[68:64];
         rs1_addr = ($urandom_range(0, 1) == 0) ? prd : 5'($urandom);
         rs2_addr = 5'($urandom);
         #1;
         n_tests++; if (rs1_data !== exp_read(rs1_addr)) begin n_fail++; $display("FAIL rnd_rs1 c%0d a%0d: got %h want %h", c, rs1_addr, rs1_data, exp_read(rs1_addr)); end
         n_tests++; if (rs2_data !== exp_read(rs2_addr)) begin n_fail++; $display("FAIL rnd_rs2 c%0d a%0d: got %h want %h", c, rs2_addr, rs2_data, exp_read(rs2_addr)); end
         n_tests++; if (trace_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_tvalid c%0d: got %b want %b", c, trace_valid, mq.size() > 0); end
         if (mq.size() > 0) begin
            n_tests++; if (trace_data !== mq[0]) begin n_fail++; $display("FAIL rnd_tdata c%0d: got %h want %h", c, trace_data, mq[0]); end
         end
         n_tests++; if (retire_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, retire_count, m_cnt); end
         n_tests++; if (w4_retire_count !== 4'(m_cnt % 16)) begin n_fail++; $display("FAIL rnd_count4 c%0d: got %0d want %0d", c, w4_retire_count, m_cnt % 16); end
         n_tests++; if (trace_overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, trace_overflow, m_ovf); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bypass();
      test_r0();
      test_overflow();
      test_full_push_pop();
      test_reset_pending();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
